// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : General-purpose register file with write-back bypass and a
//            per-register write-pending scoreboard driving decode stall.
// Revision : 1.0
// ============================================================================
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] RSaddr_i,
    input  logic [ADDR_W-1:0] RTaddr_i,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    input  logic [ADDR_W-1:0] RDaddr_i,
    input  logic [DATA_W-1:0] RDdata_i,
    input  logic              RegWrite_i,
    input  logic              issue_valid_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    output logic              RSbusy_o,
    output logic              RTbusy_o,
    output logic              stall_o
);

    localparam int   DEPTH   = 2**ADDR_W;
    localparam logic ZERO_EN = (ZERO_REG != 0);
    localparam logic BYP_EN  = (BYPASS != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic wr_en;
    logic iss_en;
    logic rs_hit;
    logic rt_hit;
    logic rs_zero;
    logic rt_zero;

    // Writes to a hardwired zero register are suppressed before they reach
    // either the array or the bypass network.
    assign wr_en = RegWrite_i && !(ZERO_EN && (RDaddr_i == '0));

    always_comb begin
        rs_hit   = BYP_EN && wr_en && (RDaddr_i == RSaddr_i);
        rs_zero  = ZERO_EN && (RSaddr_i == '0);
        RSdata_o = mem_q[RSaddr_i];
        if (rs_hit) begin
            RSdata_o = RDdata_i;
        end
        if (rs_zero) begin
            RSdata_o = '0;
        end
        RSbusy_o = busy_q[RSaddr_i] & ~rs_hit;
    end

    always_comb begin
        rt_hit   = BYP_EN && wr_en && (RDaddr_i == RTaddr_i);
        rt_zero  = ZERO_EN && (RTaddr_i == '0);
        RTdata_o = mem_q[RTaddr_i];
        if (rt_hit) begin
            RTdata_o = RDdata_i;
        end
        if (rt_zero) begin
            RTdata_o = '0;
        end
        RTbusy_o = busy_q[RTaddr_i] & ~rt_hit;
    end

    assign stall_o = RSbusy_o | RTbusy_o;

    // A stalled issue is dropped; decode re-presents it next cycle.
    assign iss_en = issue_valid_i && !stall_o
                    && !(ZERO_EN && (issue_addr_i == '0));

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wr_en) begin
            mem_d[RDaddr_i]  = RDdata_i;
            busy_d[RDaddr_i] = 1'b0;
        end
        // Issue is applied after write-back so the new producer wins.
        if (iss_en) begin
            busy_d[issue_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Directed scoreboard bench for regfile_sb (bypass, no-bypass and
//            wide configurations).
// Revision : 1.0
// ============================================================================
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs_a, rt_a, rd_a, ia;
    logic [31:0] rd_d;
    logic        we, iv;

    logic [31:0] a_rs_d, a_rt_d, b_rs_d, b_rt_d;
    logic        a_rs_b, a_rt_b, a_st, b_rs_b, b_rt_b, b_st;

    logic [3:0]  w_rs_a, w_rt_a, w_rd_a, w_ia;
    logic [63:0] w_rd_d, w_rs_d, w_rt_d;
    logic        w_we, w_iv, w_rs_b, w_rt_b, w_st;

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb[$];
    logic [63:0] wm[16];

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n),
        .RSaddr_i(rs_a), .RTaddr_i(rt_a), .RSdata_o(a_rs_d), .RTdata_o(a_rt_d),
        .RDaddr_i(rd_a), .RDdata_i(rd_d), .RegWrite_i(we),
        .issue_valid_i(iv), .issue_addr_i(ia),
        .RSbusy_o(a_rs_b), .RTbusy_o(a_rt_b), .stall_o(a_st)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n),
        .RSaddr_i(rs_a), .RTaddr_i(rt_a), .RSdata_o(b_rs_d), .RTdata_o(b_rt_d),
        .RDaddr_i(rd_a), .RDdata_i(rd_d), .RegWrite_i(we),
        .issue_valid_i(iv), .issue_addr_i(ia),
        .RSbusy_o(b_rs_b), .RTbusy_o(b_rt_b), .stall_o(b_st)
    );

    regfile_sb #(.DATA_W(64), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dut_w (
        .clk_i(clk), .rst_n_i(rst_n),
        .RSaddr_i(w_rs_a), .RTaddr_i(w_rt_a), .RSdata_o(w_rs_d), .RTdata_o(w_rt_d),
        .RDaddr_i(w_rd_a), .RDdata_i(w_rd_d), .RegWrite_i(w_we),
        .issue_valid_i(w_iv), .issue_addr_i(w_ia),
        .RSbusy_o(w_rs_b), .RTbusy_o(w_rt_b), .stall_o(w_st)
    );

    task automatic push(input logic [63:0] v);
        sb.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; rd_a = '0; rd_d = '0; iv = 1'b0; ia = '0;
    endtask

    function automatic logic [63:0] wval(input int i);
        return 64'h0123_4567_89AB_CDEF ^ (64'h1111_1111_1111_1111 * 64'(i + 1));
    endfunction

    initial begin
        rst_n = 1'b0; idle(); rs_a = '0; rt_a = '0;
        w_we = 1'b0; w_rd_a = '0; w_rd_d = '0; w_iv = 1'b0; w_ia = '0;
        w_rs_a = '0; w_rt_a = '0;
        cyc(); cyc();
        rst_n = 1'b1;

        // Reset state: every address reads zero, nothing busy.
        for (int a = 0; a < 32; a++) begin
            rs_a = 5'(a); rt_a = 5'(31 - a); #1;
            push(64'h0); chk($sformatf("rst_rs_r%0d", a), {32'h0, a_rs_d});
            push(64'h0); chk($sformatf("rst_rt_r%0d", a), {32'h0, a_rt_d});
            push(64'h0); chk($sformatf("rst_stall_r%0d", a), {63'h0, a_st});
        end

        // Write r5, then reset clears it; write/issue during the reset edge are ignored.
        idle(); we = 1'b1; rd_a = 5'd5; rd_d = 32'hDEAD_BEEF;
        cyc(); idle(); rs_a = 5'd5; #1;
        push(64'hDEAD_BEEF); chk("r5_written", {32'h0, a_rs_d});
        rst_n = 1'b0; we = 1'b1; rd_a = 5'd6; rd_d = 32'h6666_6666; iv = 1'b1; ia = 5'd8;
        cyc(); rst_n = 1'b1; idle(); #1;
        push(64'h0); chk("r5_after_reset", {32'h0, a_rs_d});
        rs_a = 5'd6; rt_a = 5'd8; #1;
        push(64'h0); chk("r6_wr_in_reset", {32'h0, a_rs_d});
        push(64'h0); chk("r8_iss_in_reset", {63'h0, a_rt_b});

        // Zero register: writes, bypass and issues to r0 have no effect.
        rs_a = 5'd0; rt_a = 5'd0; we = 1'b1; rd_a = 5'd0; rd_d = 32'h1234_5678; #1;
        push(64'h0); chk("r0_bypass_rs", {32'h0, a_rs_d});
        cyc(); idle(); #1;
        push(64'h0); chk("r0_rs", {32'h0, a_rs_d});
        push(64'h0); chk("r0_rt", {32'h0, a_rt_d});
        iv = 1'b1; ia = 5'd0;
        cyc(); idle(); #1;
        push(64'h0); chk("r0_busy", {63'h0, a_rs_b});
        push(64'h0); chk("r0_stall", {63'h0, a_st});

        // Same-cycle bypass versus array-only read.
        we = 1'b1; rd_a = 5'd7; rd_d = 32'h0000_1111;
        cyc(); idle();
        rs_a = 5'd7; rt_a = 5'd7; we = 1'b1; rd_a = 5'd7; rd_d = 32'hA5A5_A5A5; #1;
        push(64'hA5A5_A5A5); chk("byp_rs", {32'h0, a_rs_d});
        push(64'hA5A5_A5A5); chk("byp_rt", {32'h0, a_rt_d});
        push(64'h1111);      chk("nobyp_rs_old", {32'h0, b_rs_d});
        push(64'h1111);      chk("nobyp_rt_old", {32'h0, b_rt_d});
        cyc(); idle(); #1;
        push(64'hA5A5_A5A5); chk("nobyp_rs_next", {32'h0, b_rs_d});

        // Scoreboard: issue r3, stalled issue of r9 dropped, write-back clears.
        rs_a = 5'd0; rt_a = 5'd0; iv = 1'b1; ia = 5'd3;
        cyc(); idle(); rs_a = 5'd3; #1;
        push(64'h1); chk("r3_busy", {63'h0, a_rs_b});
        push(64'h1); chk("r3_stall", {63'h0, a_st});
        push(64'h1); chk("nobyp_r3_stall", {63'h0, b_st});
        iv = 1'b1; ia = 5'd9;
        cyc(); idle(); rs_a = 5'd9; rt_a = 5'd0; #1;
        push(64'h0); chk("r9_dropped", {63'h0, a_rs_b});
        rs_a = 5'd3; rt_a = 5'd3; we = 1'b1; rd_a = 5'd3; rd_d = 32'h55; #1;
        push(64'h0);  chk("wb_r3_busy", {63'h0, a_rs_b});
        push(64'h0);  chk("wb_r3_rt_busy", {63'h0, a_rt_b});
        push(64'h55); chk("wb_r3_data", {32'h0, a_rs_d});
        push(64'h0);  chk("wb_r3_stall", {63'h0, a_st});
        push(64'h1);  chk("nobyp_wb_r3_busy", {63'h0, b_rs_b});
        push(64'h1);  chk("nobyp_wb_r3_stall", {63'h0, b_st});
        cyc(); idle(); #1;
        push(64'h0);  chk("nobyp_r3_cleared", {63'h0, b_st});

        // Same edge write-back and issue to r4: data written, busy stays set.
        rs_a = 5'd0; rt_a = 5'd0; we = 1'b1; rd_a = 5'd4; rd_d = 32'hCAFE_0004;
        iv = 1'b1; ia = 5'd4;
        cyc(); idle(); rs_a = 5'd4; rt_a = 5'd4; #1;
        push(64'h1);          chk("r4_busy_rs", {63'h0, a_rs_b});
        push(64'h1);          chk("r4_busy_rt", {63'h0, a_rt_b});
        push(64'hCAFE_0004);  chk("r4_data", {32'h0, a_rs_d});
        push(64'h1);          chk("r4_stall", {63'h0, a_st});

        // Wide configuration sweep; r0 write attempted and must stay zero.
        for (int i = 0; i < 16; i++) begin
            wm[i] = (i == 0) ? 64'h0 : wval(i);
            w_we = 1'b1; w_rd_a = 4'(i); w_rd_d = wval(i);
            cyc();
        end
        w_we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w_rs_a = 4'(i); w_rt_a = 4'((i + 5) % 16); #1;
            push(wm[i]);            chk($sformatf("wide_rs_r%0d", i), w_rs_d);
            push(wm[(i + 5) % 16]); chk($sformatf("wide_rt_r%0d", (i + 5) % 16), w_rt_d);
        end
        w_rs_a = 4'd9; w_rt_a = 4'd9; #1;
        push(wm[9]); chk("wide_same_rs", w_rs_d);
        push(wm[9]); chk("wide_same_rt", w_rt_d);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
